tx_lanes: RTL and testbench

Four-lane serial link transmitter, the transmit-side counterpart of the lane receiver. It accepts a byte stream over a valid/ready handshake and stripes each group of four bytes across lanes L0..L3, one byte per lane. Each lane carries one 8-bit symbol every 8 enabled cycles, serialised MSB first. Packets are framed with COM, STP and END control symbols, and IDLE symbols fill the lanes between packets.

---
 rtl/tx_lanes.sv | 151 +++++++++++++++
 tb/tb_tx_lanes.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_lanes.sv
// rtl/tx_lanes.sv - four-lane framed serial transmitter with a four-byte staging buffer
module tx_lanes (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    output logic       ready,
    output logic       busy,
    output logic       L0,
    output logic       L1,
    output logic       L2,
    output logic       L3
);
    localparam logic [7:0] IDLE_SYM = 8'h7C;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] STP_SYM  = 8'hFB;
    localparam logic [7:0] END_SYM  = 8'hFD;
    localparam logic [7:0] PAD_SYM  = 8'hF7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COM,
        ST_STP,
        ST_DATA,
        ST_END
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] sreg    [4];
    logic [7:0] sym_nxt [4];
    logic [7:0] wbuf    [4];
    logic [2:0] bitcnt;
    logic [2:0] wcnt;
    logic       wlast;
    logic       sent_last;
    logic       sent_last_nxt;
    logic       flush;
    logic       boundary;
    logic       accept;

    // ready is masked in the boundary cycle so a symbol load never races an accept
    assign boundary = enb && (bitcnt == 3'd7);
    assign ready    = enb && reset && (wcnt < 3'd4) && !wlast && (bitcnt != 3'd7);
    assign accept   = valid && ready;
    assign busy     = (state != ST_IDLE) || (wcnt != 3'd0);

    assign L0 = sreg[0][7];
    assign L1 = sreg[1][7];
    assign L2 = sreg[2][7];
    assign L3 = sreg[3][7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (boundary) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sent_last_nxt = sent_last;
        flush         = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sym_nxt[k] = IDLE_SYM;
        end
        case (state)
            ST_IDLE: begin
                if (wcnt != 3'd0) begin
                    state_nxt = ST_COM;
                    for (int k = 0; k < 4; k++) begin
                        sym_nxt[k] = COM_SYM;
                    end
                end
            end
            ST_COM: begin
                state_nxt = ST_STP;
                for (int k = 0; k < 4; k++) begin
                    sym_nxt[k] = STP_SYM;
                end
            end
            ST_STP, ST_DATA: begin
                if ((state == ST_DATA) && sent_last) begin
                    state_nxt     = ST_END;
                    sent_last_nxt = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        sym_nxt[k] = END_SYM;
                    end
                end else if ((wcnt == 3'd4) || wlast) begin
                    state_nxt     = ST_DATA;
                    sent_last_nxt = wlast;
                    flush         = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        sym_nxt[k] = (3'(k) < wcnt) ? wbuf[k] : PAD_SYM;
                    end
                end else begin
                    // underrun: keep the partial group and fill this symbol time
                    state_nxt = ST_DATA;
                    for (int k = 0; k < 4; k++) begin
                        sym_nxt[k] = PAD_SYM;
                    end
                end
            end
            ST_END: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt    <= 3'd0;
            wcnt      <= 3'd0;
            wlast     <= 1'b0;
            sent_last <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sreg[k] <= IDLE_SYM;
                wbuf[k] <= 8'h00;
            end
        end else if (enb) begin
            bitcnt <= bitcnt + 3'd1;
            if (boundary) begin
                sent_last <= sent_last_nxt;
                for (int k = 0; k < 4; k++) begin
                    sreg[k] <= sym_nxt[k];
                end
                if (flush) begin
                    wcnt  <= 3'd0;
                    wlast <= 1'b0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    sreg[k] <= {sreg[k][6:0], 1'b0};
                end
                if (accept) begin
                    wbuf[wcnt[1:0]] <= data;
                    wcnt            <= wcnt + 3'd1;
                    if (last) begin
                        wlast <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_lanes.sv
// tb/tb_tx_lanes.sv - directed and randomized self-checking bench for tx_lanes
`timescale 1ns/1ps
module tb_tx_lanes;
    localparam logic [7:0] IDLE_SYM = 8'h7C;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] STP_SYM  = 8'hFB;
    localparam logic [7:0] END_SYM  = 8'hFD;
    localparam logic [7:0] PAD_SYM  = 8'hF7;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       enb   = 1'b1;
    logic       valid = 1'b0;
    logic       last  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready, busy, L0, L1, L2, L3;

    tx_lanes dut (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .data  (data),
        .valid (valid),
        .last  (last),
        .ready (ready),
        .busy  (busy),
        .L0    (L0),
        .L1    (L1),
        .L2    (L2),
        .L3    (L3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_enb = 1'b0;

    always @(posedge clk) cyc++;

    // Reference: symbol stream decided per symbol time from a queue of staged bytes
    logic [7:0] m_cur [4] = '{IDLE_SYM, IDLE_SYM, IDLE_SYM, IDLE_SYM};
    int         m_pos     = 0;
    bit         m_cur_idle = 1'b1;
    bit         m_in_pkt   = 1'b0;
    logic [8:0] m_q[$];
    logic [7:0] m_script[$];
    int         m_accepts = 0;

    function automatic bit m_ready_f();
        return enb && reset && (m_q.size() < 4) &&
               !((m_q.size() > 0) && m_q[m_q.size()-1][8]) && (m_pos != 7);
    endfunction

    task automatic m_all(input logic [7:0] s);
        for (int k = 0; k < 4; k++) m_cur[k] = s;
    endtask

    task automatic m_next_symbol();
        int n;
        bit lst;
        if (m_script.size() > 0) begin
            logic [7:0] s;
            s = m_script.pop_front();
            m_all(s);
            m_cur_idle = (s == IDLE_SYM);
        end else if (!m_in_pkt) begin
            if (m_q.size() > 0) begin
                m_all(COM_SYM);
                m_script.push_back(STP_SYM);
                m_in_pkt   = 1'b1;
                m_cur_idle = 1'b0;
            end else begin
                m_all(IDLE_SYM);
                m_cur_idle = 1'b1;
            end
        end else begin
            n   = m_q.size();
            lst = (n > 0) && m_q[n-1][8];
            m_cur_idle = 1'b0;
            if ((n == 4) || lst) begin
                for (int k = 0; k < 4; k++) m_cur[k] = (k < n) ? m_q[k][7:0] : PAD_SYM;
                m_q.delete();
                if (lst) begin
                    m_script.push_back(END_SYM);
                    m_script.push_back(IDLE_SYM);
                    m_in_pkt = 1'b0;
                end
            end else begin
                m_all(PAD_SYM);
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_all(IDLE_SYM);
            m_pos      = 0;
            m_cur_idle = 1'b1;
            m_in_pkt   = 1'b0;
            m_q.delete();
            m_script.delete();
        end else if (enb) begin
            if (valid && m_ready_f()) begin
                m_q.push_back({last, data});
                m_accepts++;
            end
            if (m_pos == 7) begin
                m_next_symbol();
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare plus symbol capture from the lane pins
    logic [7:0]  cap [4];
    logic [31:0] log_q[$];
    int          log_t[$];

    always @(negedge clk) begin
        logic [3:0] exp_l;
        for (int k = 0; k < 4; k++) exp_l[k] = m_cur[k][7-m_pos];
        chk("lanes", {28'd0, L3, L2, L1, L0}, {28'd0, exp_l});
        chk("ready", {31'd0, ready}, {31'd0, m_ready_f()});
        chk("busy", {31'd0, busy}, {31'd0, (!m_cur_idle || (m_q.size() != 0))});
        if (reset && enb) begin
            cap[0] = {cap[0][6:0], L0};
            cap[1] = {cap[1][6:0], L1};
            cap[2] = {cap[2][6:0], L2};
            cap[3] = {cap[3][6:0], L3};
            if (m_pos == 7) begin
                log_q.push_back({cap[3], cap[2], cap[1], cap[0]});
                log_t.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_enb) enb = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int start;
        int budget;
        start  = m_accepts;
        budget = 0;
        data   = d;
        last   = l;
        valid  = 1'b1;
        while ((m_accepts == start) && (budget < 200)) begin
            @(posedge clk);
            #1;
            budget++;
            #1;
            if (rand_enb) enb = ($urandom_range(0, 7) != 0);
        end
        valid = 1'b0;
        last  = 1'b0;
        if (budget >= 200) chk("send_timeout", budget, 0);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((!m_cur_idle || (m_q.size() != 0) || (m_script.size() != 0) || m_in_pkt) && (b < 400)) begin
            tick(1);
            b++;
        end
        if (b >= 400) chk("idle_timeout", b, 0);
        tick(20);
    endtask

    logic [31:0] exp_syms[$];

    task automatic check_log(input string name, output int first);
        int i;
        i = 0;
        while ((i < log_q.size()) && (log_q[i] == 32'h7C7C7C7C)) i++;
        first = i;
        foreach (exp_syms[j]) begin
            if (i + j < log_q.size()) chk(name, log_q[i+j], exp_syms[j]);
            else chk({name, "_missing"}, log_q.size(), i + j + 1);
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        log_t.delete();
    endtask

    initial begin
        int first;
        int b;
        int len;

        // reset and idle pattern
        tick(4);
        chk("rst_lanes", {L3, L2, L1, L0}, 4'h0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", ready, 1'b1);
        clear_log();
        tick(40);
        chk("idle_count", (log_q.size() >= 4), 1'b1);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("idle_sym", log_q[i], 32'h7C7C7C7C);

        // full four-byte packet
        clear_log();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        wait_idle();
        exp_syms = '{32'hBCBCBCBC, 32'hFBFBFBFB, 32'h04030201, 32'hFDFDFDFD, 32'h7C7C7C7C};
        check_log("full_pkt", first);

        // short packet padded
        clear_log();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        wait_idle();
        exp_syms = '{32'hBCBCBCBC, 32'hFBFBFBFB, 32'hF7F70201, 32'hFDFDFDFD, 32'h7C7C7C7C};
        check_log("short_pkt", first);

        // two groups with an underrun between them
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
        b = 0;
        while ((m_q.size() != 0) && (b < 100)) begin tick(1); b++; end
        if (b >= 100) chk("flush_timeout", b, 0);
        tick(10);
        for (int i = 4; i < 8; i++) send_byte(8'h10 + 8'(i), i == 7);
        wait_idle();
        exp_syms = '{32'hBCBCBCBC, 32'hFBFBFBFB, 32'h13121110, 32'hF7F7F7F7,
                     32'h17161514, 32'hFDFDFDFD, 32'h7C7C7C7C};
        check_log("underrun_pkt", first);

        // enable stall in the middle of a DATA symbol
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i), i == 3);
        b = 0;
        while (!((m_cur[0] == 8'hA1) && !m_cur_idle) && (b < 100)) begin tick(1); b++; end
        if (b >= 100) chk("data_timeout", b, 0);
        tick(3);
        enb = 1'b0;
        tick(5);
        enb = 1'b1;
        wait_idle();
        exp_syms = '{32'hBCBCBCBC, 32'hFBFBFBFB, 32'hA4A3A2A1, 32'hFDFDFDFD, 32'h7C7C7C7C};
        check_log("stall_pkt", first);
        if (first + 2 < log_t.size()) chk("stall_len", log_t[first+2] - log_t[first+1], 13);
        else chk("stall_len_missing", log_t.size(), first + 3);

        // reset during STP aborts the packet
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        b = 0;
        while (!((m_cur[0] == STP_SYM) && !m_cur_idle) && (b < 100)) begin tick(1); b++; end
        if (b >= 100) chk("stp_timeout", b, 0);
        tick(2);
        reset = 1'b0;
        #1;
        chk("midrst_lanes", {L3, L2, L1, L0}, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        tick(3);
        reset = 1'b1;
        clear_log();
        tick(20);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b1);
        wait_idle();
        exp_syms = '{32'hBCBCBCBC, 32'hFBFBFBFB, 32'hF7232221, 32'hFDFDFDFD, 32'h7C7C7C7C};
        check_log("after_reset_pkt", first);

        // randomized packets, gaps and enable drops against the model
        rand_enb = 1'b1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 11);
            for (int i = 0; i < len; i++) begin
                tick($urandom_range(0, 2));
                send_byte(8'($urandom), i == len - 1);
            end
            tick($urandom_range(0, 12));
        end
        rand_enb = 1'b0;
        enb = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
